// File: rtl/memory_access_stage_if.sv
// Bundle of execute-side, data-memory and writeback signals for the memory access stage.
//   slave  : the stage itself (consumes ex_* and dmem_ack/rdata, drives everything else)
//   master : surrounding pipeline and data memory (the opposite directions)
interface memory_access_stage_if #(
  parameter int unsigned XLEN = 32
);
  // Execute-stage side
  logic              ex_valid;
  logic              ex_ready;
  logic [XLEN-1:0]   ex_alu_result;
  logic [XLEN-1:0]   ex_store_data;
  logic [4:0]        ex_rd_addr;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [2:0]        ex_funct3;
  // Data-memory side
  logic              dmem_req;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic [XLEN/8-1:0] dmem_be;
  logic              dmem_ack;
  logic [XLEN-1:0]   dmem_rdata;
  // Writeback side
  logic              wb_valid;
  logic [XLEN-1:0]   wb_LMD;
  logic [XLEN-1:0]   wb_address;
  logic              wb_mem_to_reg;
  logic [4:0]        wb_rd_addr;
  logic              wb_write_en;
  logic              misalign_err;

  modport slave (
    input  ex_valid, ex_alu_result, ex_store_data, ex_rd_addr, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_funct3, dmem_ack, dmem_rdata,
    output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
           wb_valid, wb_LMD, wb_address, wb_mem_to_reg, wb_rd_addr, wb_write_en,
           misalign_err
  );

  modport master (
    output ex_valid, ex_alu_result, ex_store_data, ex_rd_addr, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_funct3, dmem_ack, dmem_rdata,
    input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
           wb_valid, wb_LMD, wb_address, wb_mem_to_reg, wb_rd_addr, wb_write_en,
           misalign_err
  );
endinterface

// File: rtl/memory_access_stage.sv
// Memory access pipeline stage. Non-memory instructions pass to writeback with one cycle of
// latency; aligned loads/stores issue one data-memory request and complete on dmem_ack;
// misaligned accesses are dropped with a one-cycle misalign_err pulse.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : memory_access_stage_if.slave (execute inputs, dmem request/response, writeback outputs)
module memory_access_stage #(
  parameter int unsigned XLEN = 32
) (
  input logic                   clk,
  input logic                   rst,
  memory_access_stage_if.slave  bus
);
  localparam int unsigned NB = XLEN / 8;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic            dmem_req_q, dmem_req_d;
  logic            dmem_we_q, dmem_we_d;
  logic [XLEN-1:0] dmem_addr_q, dmem_addr_d;
  logic [XLEN-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [NB-1:0]   dmem_be_q, dmem_be_d;
  logic            wb_valid_q, wb_valid_d;
  logic [XLEN-1:0] wb_lmd_q, wb_lmd_d;
  logic [XLEN-1:0] wb_address_q, wb_address_d;
  logic            wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [4:0]      wb_rd_addr_q, wb_rd_addr_d;
  logic            wb_write_en_q, wb_write_en_d;
  logic            misalign_err_q, misalign_err_d;
  // Fields of the in-flight memory instruction, needed once the ack arrives
  logic [XLEN-1:0] pend_addr_q, pend_addr_d;
  logic [2:0]      pend_funct3_q, pend_funct3_d;
  logic [4:0]      pend_rd_q, pend_rd_d;
  logic            pend_wen_q, pend_wen_d;
  logic            pend_load_q, pend_load_d;

  logic            is_load, is_store, is_mem, misaligned;
  logic [1:0]      ex_off;
  logic [NB-1:0]   acc_be;
  logic [XLEN-1:0] acc_wdata;
  logic [XLEN-1:0] rdata_shift;
  logic [XLEN-1:0] load_ext;

  // Read+write together is treated as a load, so the store qualifier excludes it
  assign is_load  = bus.ex_mem_read;
  assign is_store = bus.ex_mem_write & ~bus.ex_mem_read;
  assign is_mem   = is_load | is_store;
  assign ex_off   = bus.ex_alu_result[1:0];

  // Size decode: funct3[1:0] = 00 byte, 01 half, otherwise word
  always_comb begin
    misaligned = 1'b0;
    acc_be     = '1;
    acc_wdata  = bus.ex_store_data;
    case (bus.ex_funct3[1:0])
      2'b00: begin
        acc_be    = NB'(1) << ex_off;
        acc_wdata = {NB{bus.ex_store_data[7:0]}};
      end
      2'b01: begin
        misaligned = ex_off[0];
        acc_be     = NB'(3) << ex_off;
        acc_wdata  = {(NB/2){bus.ex_store_data[15:0]}};
      end
      default: misaligned = (ex_off != 2'b00);
    endcase
  end

  assign rdata_shift = bus.dmem_rdata >> {pend_addr_q[1:0], 3'b000};

  always_comb begin
    case (pend_funct3_q)
      3'b000:  load_ext = {{(XLEN-8){rdata_shift[7]}}, rdata_shift[7:0]};
      3'b001:  load_ext = {{(XLEN-16){rdata_shift[15]}}, rdata_shift[15:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, rdata_shift[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, rdata_shift[15:0]};
      default: load_ext = bus.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    dmem_req_d      = dmem_req_q;
    dmem_we_d       = dmem_we_q;
    dmem_addr_d     = dmem_addr_q;
    dmem_wdata_d    = dmem_wdata_q;
    dmem_be_d       = dmem_be_q;
    wb_valid_d      = 1'b0;
    wb_lmd_d        = wb_lmd_q;
    wb_address_d    = wb_address_q;
    wb_mem_to_reg_d = wb_mem_to_reg_q;
    wb_rd_addr_d    = wb_rd_addr_q;
    wb_write_en_d   = wb_write_en_q;
    misalign_err_d  = 1'b0;
    pend_addr_d     = pend_addr_q;
    pend_funct3_d   = pend_funct3_q;
    pend_rd_d       = pend_rd_q;
    pend_wen_d      = pend_wen_q;
    pend_load_d     = pend_load_q;

    case (state_q)
      IDLE: begin
        if (bus.ex_valid) begin
          if (is_mem && !misaligned) begin
            dmem_req_d    = 1'b1;
            dmem_we_d     = is_store;
            dmem_addr_d   = {bus.ex_alu_result[XLEN-1:2], 2'b00};
            dmem_wdata_d  = acc_wdata;
            dmem_be_d     = acc_be;
            pend_addr_d   = bus.ex_alu_result;
            pend_funct3_d = bus.ex_funct3;
            pend_rd_d     = bus.ex_rd_addr;
            pend_wen_d    = bus.ex_reg_write && (bus.ex_rd_addr != 5'd0) && !is_store;
            pend_load_d   = is_load;
            state_d       = WAIT;
          end else begin
            // Non-memory op, or a misaligned access retired without touching memory
            wb_valid_d      = 1'b1;
            wb_address_d    = bus.ex_alu_result;
            wb_mem_to_reg_d = is_load;
            wb_rd_addr_d    = bus.ex_rd_addr;
            wb_write_en_d   = bus.ex_reg_write && (bus.ex_rd_addr != 5'd0) && !is_mem;
            misalign_err_d  = is_mem;
          end
        end
      end
      default: begin
        if (bus.dmem_ack) begin
          dmem_req_d      = 1'b0;
          wb_valid_d      = 1'b1;
          wb_address_d    = pend_addr_q;
          wb_mem_to_reg_d = pend_load_q;
          wb_rd_addr_d    = pend_rd_q;
          wb_write_en_d   = pend_wen_q;
          if (pend_load_q) wb_lmd_d = load_ext;
          state_d         = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      dmem_req_q      <= 1'b0;
      dmem_we_q       <= 1'b0;
      dmem_addr_q     <= '0;
      dmem_wdata_q    <= '0;
      dmem_be_q       <= '0;
      wb_valid_q      <= 1'b0;
      wb_lmd_q        <= '0;
      wb_address_q    <= '0;
      wb_mem_to_reg_q <= 1'b0;
      wb_rd_addr_q    <= 5'd0;
      wb_write_en_q   <= 1'b0;
      misalign_err_q  <= 1'b0;
      pend_addr_q     <= '0;
      pend_funct3_q   <= 3'd0;
      pend_rd_q       <= 5'd0;
      pend_wen_q      <= 1'b0;
      pend_load_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      dmem_req_q      <= dmem_req_d;
      dmem_we_q       <= dmem_we_d;
      dmem_addr_q     <= dmem_addr_d;
      dmem_wdata_q    <= dmem_wdata_d;
      dmem_be_q       <= dmem_be_d;
      wb_valid_q      <= wb_valid_d;
      wb_lmd_q        <= wb_lmd_d;
      wb_address_q    <= wb_address_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
      wb_rd_addr_q    <= wb_rd_addr_d;
      wb_write_en_q   <= wb_write_en_d;
      misalign_err_q  <= misalign_err_d;
      pend_addr_q     <= pend_addr_d;
      pend_funct3_q   <= pend_funct3_d;
      pend_rd_q       <= pend_rd_d;
      pend_wen_q      <= pend_wen_d;
      pend_load_q     <= pend_load_d;
    end
  end

  assign bus.ex_ready      = (state_q == IDLE);
  assign bus.dmem_req      = dmem_req_q;
  assign bus.dmem_we       = dmem_we_q;
  assign bus.dmem_addr     = dmem_addr_q;
  assign bus.dmem_wdata    = dmem_wdata_q;
  assign bus.dmem_be       = dmem_be_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_LMD        = wb_lmd_q;
  assign bus.wb_address    = wb_address_q;
  assign bus.wb_mem_to_reg = wb_mem_to_reg_q;
  assign bus.wb_rd_addr    = wb_rd_addr_q;
  assign bus.wb_write_en   = wb_write_en_q;
  assign bus.misalign_err  = misalign_err_q;
endmodule
